// File: rtl/wb_uart_tx_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register map, STAT layout,
// serialiser states and small helpers.
package wb_uart_tx_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF_LSB = 8;
  localparam int STAT_LVL_LSB = 16;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO, 2**AW deep; pointers carry one extra wrap bit so full and
// empty can be told apart.
module uart_tx_fifo
  import wb_uart_tx_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  logic [DATA_W-1:0] mem_r [2**AW];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Pointer update; a reset discards whatever was queued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

  assign rdata = mem_r[rd_ptr_r[AW-1:0]];
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign level = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-slave 8N1 UART transmitter: register decode, TX FIFO, bit timer and
// serialiser, plus a level "TX drained" interrupt.
module wb_uart_tx
  import wb_uart_tx_pkg::*;
#(
  parameter int DIV_RESET = 868,
  parameter int FIFO_AW   = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        uart_tx_o,
  output logic        irq_o
);

  logic              ack_r;
  logic [31:0]       dat_r;
  logic [15:0]       div_r;
  logic              ctrl_r;
  logic [7:0]        ovf_r;
  logic              req_s, wr_s, push_s, pop_s, full_s, empty_s, busy_s;
  logic [1:0]        reg_idx_s;
  logic [31:0]       rdata_s;
  logic [7:0]        fifo_rdata_s;
  logic [FIFO_AW:0]  level_s;
  tx_state_e         state_r, state_next_s;
  logic [15:0]       timer_r, timer_next_s;
  logic [2:0]        bit_r, bit_next_s;
  logic [7:0]        shreg_r, shreg_next_s;
  logic              tx_r, tx_next_s, irq_r;
  logic              unused_s;

  assign unused_s  = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:16]};
  assign req_s     = wb_cyc_i & wb_stb_i & ~ack_r;
  assign wr_s      = req_s & wb_we_i;
  assign reg_idx_s = wb_adr_i[3:2];
  assign push_s    = wr_s & (reg_idx_s == REG_DATA) & wb_sel_i[0] & ~full_s;
  assign busy_s    = (state_r != ST_IDLE);

  uart_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (push_s),
    .wdata (wb_dat_i[7:0]),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level_s)
  );

  // Read-data mux for the addressed register.
  always_comb begin
    rdata_s = 32'd0;
    case (reg_idx_s)
      REG_STAT: begin
        rdata_s[STAT_FULL]                   = full_s;
        rdata_s[STAT_EMPTY]                  = empty_s;
        rdata_s[STAT_BUSY]                   = busy_s;
        rdata_s[STAT_OVF_LSB +: 8]           = ovf_r;
        rdata_s[STAT_LVL_LSB +: FIFO_AW + 1] = level_s;
      end
      REG_DIV:  rdata_s[15:0] = div_r;
      REG_CTRL: rdata_s[0]    = ctrl_r;
      default:  rdata_s = 32'd0;
    endcase
  end

  // Bus handshake and register writes; effects land on the edge that raises ack.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ack_r  <= 1'b0;
      dat_r  <= 32'd0;
      div_r  <= 16'(DIV_RESET);
      ctrl_r <= 1'b0;
      ovf_r  <= 8'd0;
    end else begin
      ack_r <= req_s;
      dat_r <= (req_s & ~wb_we_i) ? rdata_s : 32'd0;
      if (wr_s) begin
        case (reg_idx_s)
          REG_DATA: if (!(wb_sel_i[0] && !full_s)) ovf_r <= sat_inc8(ovf_r);
          REG_STAT: ovf_r <= 8'd0;
          REG_DIV:  div_r <= (wb_dat_i[15:0] < DIV_MIN) ? DIV_MIN : wb_dat_i[15:0];
          REG_CTRL: ctrl_r <= wb_dat_i[0];
          default:  ;
        endcase
      end
    end
  end

  // Serialiser next state; the timer reloads from div_r only at a bit boundary.
  always_comb begin
    state_next_s = state_r;
    timer_next_s = timer_r;
    bit_next_s   = bit_r;
    shreg_next_s = shreg_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s        = 1'b1;
          shreg_next_s = fifo_rdata_s;
          timer_next_s = div_r - 16'd1;
          bit_next_s   = 3'd0;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_r == 16'd0) begin
          timer_next_s = div_r - 16'd1;
          state_next_s = ST_DATA;
        end else begin
          timer_next_s = timer_r - 16'd1;
        end
      end
      ST_DATA: begin
        if (timer_r == 16'd0) begin
          timer_next_s = div_r - 16'd1;
          if (bit_r == 3'd7) begin
            state_next_s = ST_STOP;
          end else begin
            bit_next_s   = bit_r + 3'd1;
            shreg_next_s = {1'b0, shreg_r[7:1]};
          end
        end else begin
          timer_next_s = timer_r - 16'd1;
        end
      end
      ST_STOP: begin
        if (timer_r == 16'd0) begin
          state_next_s = ST_IDLE;
        end else begin
          timer_next_s = timer_r - 16'd1;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Line level for the upcoming state, so the wire changes on the same edge as the FSM.
  always_comb begin
    tx_next_s = 1'b1;
    case (state_next_s)
      ST_START: tx_next_s = 1'b0;
      ST_DATA:  tx_next_s = shreg_next_s[0];
      default:  tx_next_s = 1'b1;
    endcase
  end

  // Serialiser state, line and interrupt registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      timer_r <= 16'd0;
      bit_r   <= 3'd0;
      shreg_r <= 8'd0;
      tx_r    <= 1'b1;
      irq_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      timer_r <= timer_next_s;
      bit_r   <= bit_next_s;
      shreg_r <= shreg_next_s;
      tx_r    <= tx_next_s;
      irq_r   <= ctrl_r & empty_s & ~busy_s;
    end
  end

  assign wb_ack_o  = ack_r;
  assign wb_dat_o  = dat_r;
  assign uart_tx_o = tx_r;
  assign irq_o     = irq_r;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx: frame-level reference model compared every
// cycle, directed scenarios with hand-computed expectations, then random traffic.
module tb_wb_uart_tx;

  localparam int DIV_RST = 868;

  logic        clk = 1'b0;
  logic        rst_n, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;
  logic        ack, tx, irq;

  always #5 clk = ~clk;

  wb_uart_tx #(.DIV_RESET(DIV_RST), .FIFO_AW(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat),
    .wb_ack_o(ack), .uart_tx_o(tx), .irq_o(irq)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc_cnt = 0;
  int   last_ack = 0;
  bit   check_en = 1'b0;
  logic hist [0:65535];

  // Reference model: byte queue, counters, and the frame currently on the wire.
  logic [7:0]  q[$];
  int          m_ovf, m_div, m_left, m_idx;
  logic        m_ctrl, m_busy, m_ack, m_tx, m_irq;
  logic [31:0] m_dat;
  logic [9:0]  m_frame;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic logic hget(input int c);
    logic [31:0] cc;
    cc = c;
    return hist[cc[15:0]];
  endfunction

  task automatic model_step();
    logic        req, full_o, empty_o, busy_o;
    int          lvl;
    logic [31:0] rv;
    logic [15:0] d;
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_div = DIV_RST; m_ctrl = 1'b0; m_busy = 1'b0;
      m_ack = 1'b0; m_dat = 32'd0; m_tx = 1'b1; m_irq = 1'b0;
      return;
    end
    req     = cyc & stb & ~m_ack;
    lvl     = q.size();
    full_o  = (lvl == 16);
    empty_o = (lvl == 0);
    busy_o  = m_busy;
    m_irq   = m_ctrl & empty_o & ~busy_o;
    case (adr[3:2])
      2'd1:    rv = 32'(full_o) | (32'(empty_o) << 1) | (32'(busy_o) << 2)
                  | (32'(m_ovf) << 8) | (32'(lvl) << 16);
      2'd2:    rv = 32'(m_div);
      2'd3:    rv = 32'(m_ctrl);
      default: rv = 32'd0;
    endcase
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_idx++;
        if (m_idx == 10) m_busy = 1'b0;
        else m_left = m_div;
      end
    end else if (!empty_o) begin
      m_frame = {1'b1, q.pop_front(), 1'b0};
      m_busy  = 1'b1;
      m_idx   = 0;
      m_left  = m_div;
    end
    m_tx  = m_busy ? m_frame[m_idx] : 1'b1;
    m_ack = req;
    m_dat = (req && !we) ? rv : 32'd0;
    if (req && we) begin
      case (adr[3:2])
        2'd0: begin
          if (sel[0] && !full_o) q.push_back(wdat[7:0]);
          else if (m_ovf < 255) m_ovf++;
        end
        2'd1: m_ovf = 0;
        2'd2: begin
          d = wdat[15:0];
          m_div = (d < 16'd2) ? 2 : int'(d);
        end
        default: m_ctrl = wdat[0];
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc_cnt++;
    #1;
    hist[cyc_cnt[15:0]] = tx;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wb_access(input logic w, input logic [1:0] r, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {28'd0, r, 2'b00}; wdat = d; sel = s;
    cycle();
    chk("ack_one_cycle_after_stb", {31'd0, ack}, 32'd1);
    rd = rdat;
    last_ack = cyc_cnt;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    cycle();
    chk("ack_single_pulse", {31'd0, ack}, 32'd0);
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(1'b1, r, d, 4'hF, dummy);
  endtask

  task automatic rd_reg(input logic [1:0] r, output logic [31:0] v);
    wb_access(1'b0, r, 32'd0, 4'hF, v);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
  endtask

  // Every-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_ack", {31'd0, ack}, {31'd0, m_ack});
      chk("model_tx",  {31'd0, tx},  {31'd0, m_tx});
      chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
      if (m_ack) chk("model_rdata", rdat, m_dat);
    end
  end

  initial begin
    logic [31:0] v;
    logic [9:0]  pat;
    int          t0, cnt, rise, r;

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
    idle(3);
    rst_n = 1'b1;
    check_en = 1'b1;

    // Reset state
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    rd_reg(2'd1, v); chk("stat_after_reset", v, 32'h0000_0002);
    rd_reg(2'd2, v); chk("div_after_reset", v, 32'd868);

    // 0xA5 at DIV=4: 10 bits of 4 clocks starting on the pop edge
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h0000_00A5);
    t0 = last_ack;
    idle(45);
    pat = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      cnt = 0;
      for (int j = 0; j < 4; j++) if (hget(t0 + 1 + 4*i + j) === pat[i]) cnt++;
      chk($sformatf("a5_bit%0d", i), 32'(cnt), 32'd4);
    end
    chk("a5_line_idle_after", {31'd0, hget(t0 + 41)}, 32'd1);

    // DIV clamp and mid-frame DIV change
    wr(2'd2, 32'd0);
    rd_reg(2'd2, v); chk("div_write0_reads2", v, 32'd2);
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h0000_0055);
    t0 = last_ack;
    wr(2'd2, 32'd8);
    idle(100);
    cnt = 0;
    for (int j = 1; j <= 4; j++) if (hget(t0 + j) === 1'b0) cnt++;
    chk("div_change_start_len", 32'(cnt), 32'd4);
    cnt = 0;
    for (int j = 5; j <= 12; j++) if (hget(t0 + j) === 1'b1) cnt++;
    chk("div_change_bit0_len", 32'(cnt), 32'd8);
    chk("div_change_bit1_start", {31'd0, hget(t0 + 13)}, 32'd0);

    // irq: two bytes, rises 83 cycles after the first DATA ack
    wr(2'd2, 32'd4);
    wr(2'd3, 32'd1);
    idle(2);
    chk("irq_idle_enabled", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h0000_003C);
    t0 = last_ack;
    chk("irq_drops_on_write", {31'd0, irq}, 32'd0);
    wr(2'd0, 32'h0000_00C3);
    rise = -1;
    for (int k = 0; k < 200 && rise < 0; k++) begin
      cycle();
      if (irq === 1'b1) rise = cyc_cnt;
    end
    chk("irq_rise_time", 32'(rise - t0), 32'd83);
    wr(2'd0, 32'h0000_0011);
    chk("irq_next_write_drops", {31'd0, irq}, 32'd0);
    idle(50);
    wr(2'd3, 32'd0);

    // Overflow with a stalled line
    wr(2'd2, 32'd100);
    for (int i = 0; i < 20; i++) wr(2'd0, 32'(i));
    rd_reg(2'd1, v); chk("stat_overflow", v, 32'h0010_0305);
    wr(2'd1, 32'd0);
    rd_reg(2'd1, v); chk("stat_ovf_cleared", v, 32'h0010_0005);

    // Reset mid DATA bit
    do_reset(2);
    rd_reg(2'd1, v); chk("stat_after_flush_reset", v, 32'h0000_0002);
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h0000_00F0);
    idle(10);
    chk("line_low_before_reset", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    cycle();
    chk("reset_mid_frame_line", {31'd0, tx}, 32'd1);
    rst_n = 1'b1;
    t0 = cyc_cnt;
    rd_reg(2'd1, v); chk("reset_mid_frame_stat", v, 32'h0000_0002);
    idle(60);
    cnt = 0;
    for (int j = 0; j < 60; j++) if (hget(t0 + j) !== 1'b1) cnt++;
    chk("no_frame_resumes", 32'(cnt), 32'd0);

    // Random traffic against the model
    wr(2'd2, 32'd3);
    repeat (500) begin
      r = $urandom_range(0, 11);
      if (r < 4) begin
        wb_access(1'b1, 2'd0, $urandom, ($urandom_range(0, 7) == 0) ? 4'hE : 4'hF, v);
      end else if (r < 6) begin
        rd_reg(2'($urandom_range(0, 3)), v);
      end else if (r == 6) begin
        wr(2'd2, 32'($urandom_range(0, 6)));
      end else if (r == 7) begin
        wr(2'd3, $urandom);
      end else if (r == 8) begin
        wr(2'd1, $urandom);
      end else if (r == 9) begin
        cyc = 1'b1; stb = 1'b1; we = 1'($urandom_range(0, 1));
        adr = {28'd0, 2'($urandom_range(0, 3)), 2'b00}; wdat = $urandom; sel = 4'hF;
        if (adr[3:2] == 2'd2) wdat = 32'($urandom_range(0, 6));
        idle($urandom_range(2, 5));
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        cycle();
      end else if (r == 10 && $urandom_range(0, 9) == 0) begin
        do_reset(1);
        wr(2'd2, 32'd3);
      end else begin
        idle($urandom_range(1, 40));
      end
    end

    idle(1500);
    rd_reg(2'd1, v); chk("final_drained_stat", v & 32'h001F_0007, 32'h0000_0002);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
